starfield_ctrl: RTL

STARFIELD_CTRL -- requirements
Module: starfield_ctrl

---
 rtl/starfield_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/starfield_ctrl.sv
// starfield_ctrl: CPU-programmable speed ramp for the starfield generator.
// Steps the current speed toward a target once every DIV vblank rising edges,
// notifying the starfield with a one-cycle write strobe after every change.
module starfield_ctrl #(
  parameter logic [7:0] DIV_RST  = 8'd1,
  parameter logic [7:0] STEP_RST = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vblank,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  input  logic       write,
  output logic [7:0] sf_data,
  output logic       sf_write,
  output logic       sf_pause,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WAIT, STEP, NOTIFY} state_t;

  state_t     state, state_nxt;
  logic [7:0] current, target, step, divider, fcnt;
  logic       snap, pause, vb_q, pending;

  logic       wr_tgt, wr_step, wr_div, wr_ctl;
  logic [7:0] step_eff, div_eff, cur_nxt;
  logic [8:0] sum9, diff9;
  logic       vb_edge, tick, go;

  assign wr_tgt  = write && (addr == 2'd0);
  assign wr_step = write && (addr == 2'd1);
  assign wr_div  = write && (addr == 2'd2);
  assign wr_ctl  = write && (addr == 2'd3);

  // A zero step or divider would stall the ramp, so both read as 1.
  assign step_eff = (step == 8'd0) ? 8'd1 : step;
  assign div_eff  = (divider == 8'd0) ? 8'd1 : divider;

  assign vb_edge = vblank & ~vb_q;
  assign tick    = vb_edge && (state != IDLE) && (fcnt == div_eff - 8'd1);
  assign go      = (state == WAIT) && en && (tick || pending);

  assign busy    = (current != target);
  assign sf_data = current;
  assign sf_pause = pause;

  // 9-bit step arithmetic clamps at the target so the speed never wraps.
  assign sum9  = {1'b0, current} + {1'b0, step_eff};
  assign diff9 = {1'b0, current} - {1'b0, step_eff};

  // Next ramp value, evaluated with the register values present during STEP.
  always_comb begin
    cur_nxt = current;
    if (current < target)
      cur_nxt = (sum9 > {1'b0, target}) ? target : sum9[7:0];
    else if (current > target)
      cur_nxt = (diff9[8] || (diff9[7:0] < target)) ? target : diff9[7:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a pending SNAP overrides every state.
  always_comb begin
    state_nxt = state;
    if (snap) begin
      state_nxt = NOTIFY;
    end else begin
      case (state)
        IDLE:    if ((wr_tgt && (data_in != current)) || busy) state_nxt = WAIT;
        WAIT:    if (go) state_nxt = STEP;
        STEP:    state_nxt = NOTIFY;
        NOTIFY:  state_nxt = (current == target) ? IDLE : WAIT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: the starfield strobe is asserted only in NOTIFY.
  always_comb begin
    sf_write = 1'b0;
    if (state == NOTIFY) sf_write = 1'b1;
  end

  // CPU-visible registers; SNAP lives for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target  <= 8'd0;
      step    <= STEP_RST;
      divider <= DIV_RST;
      snap    <= 1'b0;
      pause   <= 1'b0;
    end else begin
      snap <= wr_ctl & data_in[0];
      if (wr_tgt)  target  <= data_in;
      if (wr_step) step    <= data_in;
      if (wr_div)  divider <= data_in;
      if (wr_ctl)  pause   <= data_in[1];
    end
  end

  // Current speed: jumps on SNAP, otherwise moves one step in STEP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 current <= 8'd0;
    else if (snap)           current <= target;
    else if (state == STEP)  current <= cur_nxt;
  end

  // vblank sampling and frame counter; the counter rests at 0 while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb_q <= 1'b0;
      fcnt <= 8'd0;
    end else begin
      vb_q <= vblank;
      if (state == IDLE)  fcnt <= 8'd0;
      else if (tick)      fcnt <= 8'd0;
      else if (vb_edge)   fcnt <= fcnt + 8'd1;
    end
  end

  // One-deep pending tick so a frame tick seen with en=0 is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       pending <= 1'b0;
    else if ((state == IDLE) || go) pending <= 1'b0;
    else if (tick)                 pending <= 1'b1;
  end

endmodule
